controller2: RTL
================

CONTROLLER2 -- requirements
Module: controller2

Interface
REQ-001 Parameter ADDR_W, default 4, width of the input-RAM address counter num1C.
REQ-002 Parameter SHIFT_W, default 5, width of the accumulated-shift counter num2C.
REQ-003 Parameter PER_W, default 4, width of the per-operand shift counter num3.
REQ-004 Ports: clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begins a run from IDLE.
REQ-007 x15  in  1  MSB of the datapath shift-left register.
REQ-008 num1C  in  ADDR_W  current input-RAM address.
REQ-009 num2C  in  SHIFT_W  accumulated shift count for the current pair; monitored only, no decision logic.
REQ-010 num3  in  PER_W  shift count for the current operand.
REQ-011 clr1, en1, ld1, shL1, ld2, ld3, clr2, en2, clr3, en3, wen  out  1 each  datapath controls, Moore-decoded from state plus x15/num3/num1C.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at end of run.

Function
REQ-014 States: IDLE, INIT, LOAD_A, SHIFT_A, LOAD_B, SHIFT_B, WRITE, DONE.
REQ-015 IDLE: all controls 0; start=1 -> INIT; otherwise stay.
REQ-016 INIT: clr1=clr2=clr3=1 for one cycle -> LOAD_A.
REQ-017 LOAD_A: ld1=1, clr3=1 -> SHIFT_A.
REQ-018 SHIFT_A, normalize condition (x15=1 or num3=2^PER_W-1): ld2=1, en1=1 -> LOAD_B.
REQ-019 SHIFT_A, otherwise: shL1=1, en2=1, en3=1; stay in SHIFT_A.
REQ-020 LOAD_B: ld1=1, clr3=1 -> SHIFT_B.
REQ-021 SHIFT_B: identical to SHIFT_A with ld3 in place of ld2, en1=0, exit -> WRITE.
REQ-022 WRITE: wen=1; if num1C=2^ADDR_W-1 -> DONE; else en1=1, clr2=1 -> LOAD_A.
REQ-023 In WRITE, en1/clr2 take effect at the same edge as the write, so the write captures pre-update num1C/num2C.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 Pair latency: kA+kB+5 cycles (LOAD_A to WRITE inclusive), where k = shifts per operand, 0..15.
REQ-026 Zero operand: x15 never sets; exit after num3 reaches 15, i.e. k=15, no hang.
REQ-027 Operand A always occupies even addresses and operand B odd addresses; the outRAM address is num1C>>1.
REQ-028 start while busy=1 is ignored; start held high after DONE launches a new run from IDLE.
REQ-029 No state is entered with two of ld1/shL1 asserted; no more than one of ld2/ld3/wen is asserted in any cycle.

Reset
REQ-030 rst=1 at any edge forces IDLE; next cycle all outputs 0, busy=0, done=0.
REQ-031 Reset mid-run abandons the pair without a write; datapath counters are cleared by the following INIT, not by the controller on reset.

Structure
REQ-032 Shared package holds the state enumeration, MAX_SHIFT (=15) and LAST_ADDR (=15) constants used by the controller and the bench.
REQ-033 Single flat module with one state register, next-state logic and output decode; no sub-module.
REQ-034 The integration top pairing datapath2 and controller2 is a separate file, outside this block.

Verification
REQ-035 RAM[0]=0x8000, RAM[1]=0x8000: SHIFT_A and SHIFT_B exit on first cycle; wen 5 cycles after LOAD_A entry; num2C=0 at write; address 0.
REQ-036 RAM[2]=0x0001, RAM[3]=0x00FF: kA=15, kB=8; wen at cycle 28 after LOAD_A; num2C=23 at write.
REQ-037 RAM[4]=0x0000, RAM[5]=0x4000: A exits with num3=15, x15=0; kB=1; no hang; write at address 2.
REQ-038 Full 16-word run, all words 0x8000: exactly 8 wen pulses at addresses 0..7; one done pulse 42 cycles after start (INIT + 8x5 + DONE).
REQ-039 rst=1 during SHIFT_B of pair 3: next cycle IDLE, all outputs 0, no wen; restart rewrites addresses 0..7 correctly.
REQ-040 start pulsed during SHIFT_A: state sequence and wen count unchanged versus the baseline run.

Source files
------------

// File: rtl/controller2_pkg.sv
// Shared definitions for the controller2 normalise-and-count FSM.
package controller2_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_LOAD_A  = 3'd2,
    S_SHIFT_A = 3'd3,
    S_LOAD_B  = 3'd4,
    S_SHIFT_B = 3'd5,
    S_WRITE   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  localparam int MAX_SHIFT = 15;
  localparam int LAST_ADDR = 15;

endpackage

// File: rtl/controller2.sv
// Controller that normalises each operand pair from the input RAM and writes
// the combined shift count to the output RAM at address num1C>>1.
module controller2
  import controller2_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int SHIFT_W = 5,
  parameter int PER_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               x15,
  input  logic [ADDR_W-1:0]  num1C,
  input  logic [SHIFT_W-1:0] num2C,
  input  logic [PER_W-1:0]   num3,
  output logic               clr1,
  output logic               en1,
  output logic               ld1,
  output logic               shL1,
  output logic               ld2,
  output logic               ld3,
  output logic               clr2,
  output logic               en2,
  output logic               clr3,
  output logic               en3,
  output logic               wen,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;
  logic   norm_s;
  logic   last_s;
  logic   unused_s;

  // num2C is observed by the datapath write only; the FSM never branches on it.
  assign unused_s = ^num2C;

  assign norm_s = x15 | (num3 == {PER_W{1'b1}});
  assign last_s = (num1C == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr1    = 1'b0;
    en1     = 1'b0;
    ld1     = 1'b0;
    shL1    = 1'b0;
    ld2     = 1'b0;
    ld3     = 1'b0;
    clr2    = 1'b0;
    en2     = 1'b0;
    clr3    = 1'b0;
    en3     = 1'b0;
    wen     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        clr1    = 1'b1;
        clr2    = 1'b1;
        clr3    = 1'b1;
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        ld1     = 1'b1;
        clr3    = 1'b1;
        state_d = S_SHIFT_A;
      end
      S_SHIFT_A: begin
        if (norm_s) begin
          ld2     = 1'b1;
          en1     = 1'b1;
          state_d = S_LOAD_B;
        end else begin
          shL1    = 1'b1;
          en2     = 1'b1;
          en3     = 1'b1;
          state_d = S_SHIFT_A;
        end
      end
      S_LOAD_B: begin
        ld1     = 1'b1;
        clr3    = 1'b1;
        state_d = S_SHIFT_B;
      end
      S_SHIFT_B: begin
        if (norm_s) begin
          ld3     = 1'b1;
          state_d = S_WRITE;
        end else begin
          shL1    = 1'b1;
          en2     = 1'b1;
          en3     = 1'b1;
          state_d = S_SHIFT_B;
        end
      end
      S_WRITE: begin
        // Address/count advance on the same edge as the write, so the write sees the old values.
        wen = 1'b1;
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          en1     = 1'b1;
          clr2    = 1'b1;
          state_d = S_LOAD_A;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
